// File: rtl/uart_alu_if.sv
// Serial-driven ALU: pops {A, B, OP} frames from the UART rx FIFO and pushes the result byte
// into the tx FIFO. Defining `UART_ALU_STATUS_EN adds a status byte {Z,C,V,N,3'b000,INV}.
module uart_alu_if #(
    parameter int unsigned     DBIT    = 8,
    parameter int unsigned     TO_W    = 20,
    parameter logic [TO_W-1:0] TIMEOUT = 20'd1_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_empty,
    input  logic [DBIT-1:0] r_data,
    output logic            rd_uart,
    input  logic            tx_full,
    output logic            wr_uart,
    output logic [DBIT-1:0] w_data,
    output logic            busy,
    output logic            frame_err,
    output logic            op_err
);

    localparam int unsigned     MSB    = DBIT - 1;
    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - 1'b1;

    localparam logic [DBIT-1:0] OpAdd = 8'h20;
    localparam logic [DBIT-1:0] OpSub = 8'h22;
    localparam logic [DBIT-1:0] OpAnd = 8'h24;
    localparam logic [DBIT-1:0] OpOr  = 8'h25;
    localparam logic [DBIT-1:0] OpXor = 8'h26;
    localparam logic [DBIT-1:0] OpNor = 8'h27;
    localparam logic [DBIT-1:0] OpSrl = 8'h02;
    localparam logic [DBIT-1:0] OpSra = 8'h03;

    typedef enum logic [2:0] {
        StRdA,
        StRdB,
        StRdOp,
        StExe,
`ifdef UART_ALU_STATUS_EN
        StWrR,
        StWrS
`else
        StWrR
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [DBIT-1:0] a_q, a_d, b_q, b_d, op_q, op_d, r_q, r_d;
    logic [DBIT-1:0] w_data_q, w_data_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            rd_q, rd_d, wr_q, wr_d;
    logic            frame_err_q, frame_err_d, op_err_q, op_err_d;
    logic            take, push;
    logic [DBIT-1:0] alu_r;
    logic            alu_inv;
`ifdef UART_ALU_STATUS_EN
    logic            alu_c, alu_v;
    logic [DBIT-1:0] status_q;
`endif

    // A pop/push is never issued in the cycle its pulse is still high, so the FIFO flags and
    // head byte seen here are always settled.
    assign take = !rx_empty && !rd_q;
    assign push = !tx_full && !wr_q;

    always_comb begin
        alu_r   = '0;
        alu_inv = 1'b0;
`ifdef UART_ALU_STATUS_EN
        alu_c   = 1'b0;
        alu_v   = 1'b0;
`endif
        case (op_q)
            OpAdd: begin
`ifdef UART_ALU_STATUS_EN
                {alu_c, alu_r} = {1'b0, a_q} + {1'b0, b_q};
                alu_v = (a_q[MSB] == b_q[MSB]) && (alu_r[MSB] != a_q[MSB]);
`else
                alu_r = a_q + b_q;
`endif
            end
            OpSub: begin
`ifdef UART_ALU_STATUS_EN
                {alu_c, alu_r} = {1'b0, a_q} - {1'b0, b_q};
                alu_v = (a_q[MSB] != b_q[MSB]) && (alu_r[MSB] != a_q[MSB]);
`else
                alu_r = a_q - b_q;
`endif
            end
            OpAnd:   alu_r = a_q & b_q;
            OpOr:    alu_r = a_q | b_q;
            OpXor:   alu_r = a_q ^ b_q;
            OpNor:   alu_r = ~(a_q | b_q);
            OpSrl:   alu_r = a_q >> b_q[2:0];
            OpSra:   alu_r = $signed(a_q) >>> b_q[2:0];
            default: alu_inv = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        w_data_d    = w_data_q;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        frame_err_d = 1'b0;
        op_err_d    = 1'b0;

        unique case (state_q)
            StRdA: begin
                cnt_d = '0;
                if (take) begin
                    a_d     = r_data;
                    rd_d    = 1'b1;
                    state_d = StRdB;
                end
            end
            StRdB, StRdOp: begin
                if (take) begin
                    if (state_q == StRdB) begin
                        b_d     = r_data;
                        state_d = StRdOp;
                    end else begin
                        op_d    = r_data;
                        state_d = StExe;
                    end
                    rd_d  = 1'b1;
                    cnt_d = '0;
                end else if (cnt_q == TO_LAST) begin
                    // Stalled partial frame: drop it and resync on the next byte.
                    frame_err_d = 1'b1;
                    a_d         = '0;
                    b_d         = '0;
                    cnt_d       = '0;
                    state_d     = StRdA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StExe: begin
                r_d      = alu_r;
                op_err_d = alu_inv;
                state_d  = StWrR;
            end
            StWrR: begin
                if (push) begin
                    wr_d     = 1'b1;
                    w_data_d = r_q;
`ifdef UART_ALU_STATUS_EN
                    state_d  = StWrS;
`else
                    state_d  = StRdA;
`endif
                end
            end
`ifdef UART_ALU_STATUS_EN
            StWrS: begin
                if (push) begin
                    wr_d     = 1'b1;
                    w_data_d = status_q;
                    state_d  = StRdA;
                end
            end
`endif
            default: state_d = StRdA;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StRdA;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            w_data_q    <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            frame_err_q <= 1'b0;
            op_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            w_data_q    <= w_data_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            frame_err_q <= frame_err_d;
            op_err_q    <= op_err_d;
        end
    end

`ifdef UART_ALU_STATUS_EN
    // Z and N are meaningless for an unsupported op, so they read as 0 alongside INV.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_q <= '0;
        end else if (state_q == StExe) begin
            status_q <= {!alu_inv && (alu_r == '0), alu_c, alu_v, !alu_inv && alu_r[MSB],
                         3'b000, alu_inv};
        end
    end
`endif

    assign rd_uart   = rd_q;
    assign wr_uart   = wr_q;
    assign w_data    = w_data_q;
    assign busy      = (state_q != StRdA);
    assign frame_err = frame_err_q;
    assign op_err    = op_err_q;

endmodule
